miner_job_scheduler: RTL

//  Sequences one sha256_top mining core: accepts work jobs (midstate, data2, id) from the host link,

---
 rtl/miner_job_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/miner_job_scheduler.sv
// Job sequencer for a single sha256 mining core: double-buffers host jobs, launches the core,
// and turns each job's outcome into a result record on a valid/ready port.
module miner_job_scheduler #(
  parameter logic NONCE_HALF    = 1'b0,
  parameter int   BUSY_TIMEOUT  = 16,
  parameter int   SETTLE_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data2,
  input  logic [7:0]   work_id,
  input  logic         abort,
  output logic [255:0] core_midstate,
  output logic [95:0]  core_data2,
  output logic         core_start,
  output logic         core_nonce_start,
  input  logic         core_busy,
  input  logic         core_ticket,
  input  logic [31:0]  core_nonce,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [1:0]   res_status,
  output logic [31:0]  res_nonce,
  output logic [7:0]   res_id,
  output logic [15:0]  jobs_done,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    MINING    = 3'd3,
    DRAIN     = 3'd4,
    REPORT    = 3'd5
  } state_t;

  localparam logic [15:0] BUSY_LAST   = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t        state;
  logic          pend_valid;
  logic [255:0]  pend_midstate;
  logic [95:0]   pend_data2;
  logic [7:0]    pend_id;
  logic [7:0]    act_id;
  logic [15:0]   cnt;

  assign work_ready       = !pend_valid;
  assign core_nonce_start = NONCE_HALF;
  assign state_dbg        = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pend_valid    <= 1'b0;
      pend_midstate <= '0;
      pend_data2    <= '0;
      pend_id       <= '0;
      act_id        <= '0;
      cnt           <= '0;
      core_midstate <= '0;
      core_data2    <= '0;
      core_start    <= 1'b0;
      res_valid     <= 1'b0;
      res_status    <= 2'b00;
      res_nonce     <= '0;
      res_id        <= '0;
      jobs_done     <= '0;
    end else begin
      core_start <= 1'b0;
      // The pending slot fills whenever it is empty, whatever the FSM is doing.
      if (work_valid && !pend_valid) begin
        pend_valid    <= 1'b1;
        pend_midstate <= work_midstate;
        pend_data2    <= work_data2;
        pend_id       <= work_id;
      end
      case (state)
        IDLE: begin
          if (pend_valid) begin
            core_midstate <= pend_midstate;
            core_data2    <= pend_data2;
            act_id        <= pend_id;
            pend_valid    <= 1'b0;
            core_start    <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // got_ticket may still be left over from the previous job here.
          if (core_busy) begin
            state <= MINING;
          end else if (cnt == BUSY_LAST) begin
            res_valid  <= 1'b1;
            res_status <= 2'b10;
            res_nonce  <= '0;
            res_id     <= act_id;
            state      <= REPORT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        MINING: begin
          if (core_ticket) begin
            res_valid  <= 1'b1;
            res_status <= 2'b01;
            res_nonce  <= core_nonce;
            res_id     <= act_id;
            state      <= REPORT;
          end else if (abort || pend_valid) begin
            res_valid  <= 1'b1;
            res_status <= 2'b11;
            res_nonce  <= '0;
            res_id     <= act_id;
            state      <= REPORT;
          end else if (!core_busy) begin
            cnt   <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (core_ticket) begin
            res_valid  <= 1'b1;
            res_status <= 2'b01;
            res_nonce  <= core_nonce;
            res_id     <= act_id;
            state      <= REPORT;
          end else if (abort) begin
            res_valid  <= 1'b1;
            res_status <= 2'b11;
            res_nonce  <= '0;
            res_id     <= act_id;
            state      <= REPORT;
          end else if (cnt == SETTLE_LAST) begin
            res_valid  <= 1'b1;
            res_status <= 2'b00;
            res_nonce  <= '0;
            res_id     <= act_id;
            state      <= REPORT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            jobs_done <= jobs_done + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
